// File: rtl/switch_mem_regfile.sv
// Byte-addressed configuration register file on the switch memory bus.
// Single-beat byte writes, 32-bit little-endian reads, one-cycle ack pulse.
`timescale 1ns/1ps

module switch_mem_regfile #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned NUM_PORTS   = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   mem_sel_en,
   input  logic                   mem_wr_rd_s,
   input  logic [7:0]             mem_addr,
   input  logic [7:0]             mem_wr_data,
   output logic [31:0]            mem_rd_data,
   output logic                   mem_ack,
   output logic [NUM_PORTS*8-1:0] cfg_port_addr,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   state_t      state, next_state;
   logic [7:0]  mem [256];
   logic        armed;
   logic [2:0]  cnt;
   logic [7:0]  addr_q;
   logic [7:0]  data_q;
   logic        wr_q;

   logic        accept;
   logic        enter_ack;
   logic [7:0]  txn_addr;
   logic [7:0]  txn_data;
   logic        txn_wr;
   logic [7:0]  addr_p1, addr_p2, addr_p3;

   assign accept = (state == S_IDLE) && mem_sel_en && armed;

   // With no wait states the access completes on the accepting edge, so the
   // live bus values are used there; otherwise the latched copies are.
   always_comb begin
      if (state == S_IDLE) begin
         txn_addr = mem_addr;
         txn_data = mem_wr_data;
         txn_wr   = mem_wr_rd_s;
      end else begin
         txn_addr = addr_q;
         txn_data = data_q;
         txn_wr   = wr_q;
      end
   end

   assign addr_p1 = txn_addr + 8'd1;
   assign addr_p2 = txn_addr + 8'd2;
   assign addr_p3 = txn_addr + 8'd3;

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept)
               next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
         end
         S_WAIT: begin
            if (cnt == 3'd0)
               next_state = S_ACK;
         end
         S_ACK:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   assign enter_ack = (next_state == S_ACK) && (state != S_ACK);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         armed <= 1'b1;
      end else if (accept) begin
         armed <= 1'b0;
      end else if (!mem_sel_en) begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         addr_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
      end else if (accept) begin
         cnt    <= CNT_INIT;
         addr_q <= mem_addr;
         data_q <= mem_wr_data;
         wr_q   <= mem_wr_rd_s;
      end else if (state == S_WAIT && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem <= '{default: '0};
      end else if (enter_ack && txn_wr) begin
         mem[txn_addr] <= txn_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd_data <= '0;
      end else if (enter_ack && !txn_wr) begin
         mem_rd_data <= {mem[addr_p3], mem[addr_p2], mem[addr_p1], mem[txn_addr]};
      end
   end

   assign mem_ack = (state == S_ACK);
   assign busy    = (state != S_IDLE);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cfg
      assign cfg_port_addr[g*8 +: 8] = mem[g];
   end

endmodule

// File: tb/tb_switch_mem_regfile.sv
// Scoreboard bench for switch_mem_regfile: a main instance with one wait state
// plus zero- and three-wait-state instances for the latency sweep.
`timescale 1ns/1ps

module tb_switch_mem_regfile;

   logic        clock;
   logic        reset_n;
   logic        mem_sel_en, mem_wr_rd_s;
   logic [7:0]  mem_addr, mem_wr_data;
   logic [31:0] mem_rd_data;
   logic        mem_ack, busy;
   logic [31:0] cfg_port_addr;

   logic        sel2, wr2;
   logic [7:0]  addr2, data2;
   logic [31:0] rd0, rd3, cfg0, cfg3;
   logic        ack0, ack3, busy0, busy3;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned ack_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_rd;

   switch_mem_regfile #(.WAIT_CYCLES(1), .NUM_PORTS(4)) dut (
      .clock(clock), .reset_n(reset_n), .mem_sel_en(mem_sel_en),
      .mem_wr_rd_s(mem_wr_rd_s), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
      .cfg_port_addr(cfg_port_addr), .busy(busy)
   );

   switch_mem_regfile #(.WAIT_CYCLES(0), .NUM_PORTS(4)) u_w0 (
      .clock(clock), .reset_n(reset_n), .mem_sel_en(sel2),
      .mem_wr_rd_s(wr2), .mem_addr(addr2), .mem_wr_data(data2),
      .mem_rd_data(rd0), .mem_ack(ack0), .cfg_port_addr(cfg0), .busy(busy0)
   );

   switch_mem_regfile #(.WAIT_CYCLES(3), .NUM_PORTS(4)) u_w3 (
      .clock(clock), .reset_n(reset_n), .mem_sel_en(sel2),
      .mem_wr_rd_s(wr2), .mem_addr(addr2), .mem_wr_data(data2),
      .mem_rd_data(rd3), .mem_ack(ack3), .cfg_port_addr(cfg3), .busy(busy3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every ack pops one expected read word (writes expect it unchanged).
   always @(negedge clock) begin
      if (mem_ack === 1'b1) begin
         ack_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            chk("rd_data", mem_rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [31:0] exp_rd);
      int n;
      mem_wr_rd_s = wr;
      mem_addr    = a;
      mem_wr_data = d;
      mem_sel_en  = 1'b1;
      exp_q.push_back(wr ? last_rd : exp_rd);
      if (!wr) last_rd = exp_rd;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (mem_ack !== 1'b1 && n < 20);
      if (mem_ack !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
      mem_sel_en = 1'b0;
      @(negedge clock);
   endtask

   task automatic sweep(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [31:0] exp_rd);
      int unsigned a0_n = 0, a3_n = 0, a0_c = 0, a3_c = 0, b0_c = 0, b3_c = 0;
      logic [31:0] r0 = '0, r3 = '0;
      wr2 = wr; addr2 = a; data2 = d; sel2 = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clock);
         if (ack0) begin a0_n = n; a0_c++; r0 = rd0; end
         if (ack3) begin a3_n = n; a3_c++; r3 = rd3; end
         if (busy0) b0_c++;
         if (busy3) b3_c++;
      end
      sel2 = 1'b0;
      @(negedge clock);
      chk("w0_ack_cycle", a0_n, 1);
      chk("w3_ack_cycle", a3_n, 4);
      chk("w0_ack_count", a0_c, 1);
      chk("w3_ack_count", a3_c, 1);
      chk("w0_busy_cycles", b0_c, 1);
      chk("w3_busy_cycles", b3_c, 4);
      if (!wr) begin
         chk("w0_rd_data", r0, exp_rd);
         chk("w3_rd_data", r3, exp_rd);
      end
   endtask

   initial begin
      int unsigned acks_before;
      reset_n = 1'b0; mem_sel_en = 1'b0; mem_wr_rd_s = 1'b0;
      mem_addr = '0; mem_wr_data = '0; last_rd = '0;
      sel2 = 1'b0; wr2 = 1'b0; addr2 = '0; data2 = '0;
      repeat (2) @(negedge clock);
      chk("rst_rd_data", mem_rd_data, 32'h0);
      chk("rst_ack", {31'd0, mem_ack}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cfg", cfg_port_addr, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      txn(1'b1, 8'h10, 8'h11, 32'h0);
      txn(1'b1, 8'h11, 8'h22, 32'h0);
      txn(1'b1, 8'h12, 8'h33, 32'h0);
      txn(1'b1, 8'h13, 8'h44, 32'h0);
      txn(1'b0, 8'h10, 8'h00, 32'h44332211);
      txn(1'b0, 8'h12, 8'h00, 32'h00004433);

      txn(1'b1, 8'hFE, 8'hAA, 32'h0);
      txn(1'b1, 8'hFF, 8'hBB, 32'h0);
      txn(1'b1, 8'h00, 8'hCC, 32'h0);
      txn(1'b1, 8'h01, 8'hDD, 32'h0);
      txn(1'b0, 8'hFE, 8'h00, 32'hDDCCBBAA);
      chk("cfg_after_wrap", cfg_port_addr, 32'h0000DDCC);

      // Held strobe: bus changes during WAIT must not leak into the write.
      acks_before = ack_cnt;
      mem_wr_rd_s = 1'b1; mem_addr = 8'h02; mem_wr_data = 8'h5A; mem_sel_en = 1'b1;
      exp_q.push_back(last_rd);
      @(negedge clock);
      chk("held_busy", {31'd0, busy}, 32'd1);
      mem_addr = 8'h05; mem_wr_data = 8'hEE;
      repeat (9) @(negedge clock);
      chk("held_ack_count", ack_cnt - acks_before, 32'd1);
      mem_sel_en = 1'b0;
      @(negedge clock);
      chk("cfg_after_held", cfg_port_addr, 32'h005ADDCC);
      txn(1'b0, 8'h02, 8'h00, 32'h0000005A);

      // Abort a write mid-WAIT with reset.
      acks_before = ack_cnt;
      mem_wr_rd_s = 1'b1; mem_addr = 8'h03; mem_wr_data = 8'h77; mem_sel_en = 1'b1;
      @(negedge clock);
      chk("abort_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_ack", {31'd0, mem_ack}, 32'd0);
      chk("abort_busy_rst", {31'd0, busy}, 32'd0);
      chk("abort_rd_data", mem_rd_data, 32'h0);
      chk("abort_cfg", cfg_port_addr, 32'h0);
      mem_sel_en = 1'b0;
      last_rd = '0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("abort_no_ack", ack_cnt - acks_before, 32'd0);
      txn(1'b0, 8'h00, 8'h00, 32'h00000000);
      txn(1'b0, 8'h02, 8'h00, 32'h00000000);

      sweep(1'b1, 8'h20, 8'h99, 32'h0);
      sweep(1'b0, 8'h20, 8'h00, 32'h00000099);

      repeat (2) @(negedge clock);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
